ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader_pkg.sv | 18 +
 rtl/ram_stream_reader_fifo.sv | 65 ++++++
 rtl/ram_stream_reader.sv | 139 +++++++++++++
 tb/tb_ram_stream_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_stream_reader_pkg
// Brief    : Shared FSM encoding and FIFO sizing for the RAM stream reader.
// Revision : 1.0 - initial release
// ============================================================================
package ram_stream_reader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W      = FIFO_CNT_W + 1;

endpackage
`default_nettype wire

// File: rtl/ram_stream_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stream_fifo2
// Brief    : Registered 2-entry FIFO; simultaneous push and pop allowed.
// Revision : 1.0 - initial release
// ============================================================================
module stream_fifo2
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 65
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [FIFO_CNT_W-1:0] count,
    output logic [WIDTH-1:0]      head
);

    logic [WIDTH-1:0]      head_q, head_d;
    logic [WIDTH-1:0]      tail_q, tail_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic                  do_pop;
    logic                  do_push;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop) begin
            head_d  = tail_q;
            count_d = count_q - FIFO_CNT_W'(1);
        end
        // A push lands in whichever slot is the first free one after the pop.
        if (do_push) begin
            if (count_d == '0) begin
                head_d = push_data;
            end else begin
                tail_d = push_data;
            end
            count_d = count_d + FIFO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_stream_reader
// Brief    : Streams a burst of words from a registered-read RAM to a
//            valid/ready consumer through a 2-entry credit-limited FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  ram_port_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int LEN_W = ADDR_WIDTH + 1;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic                  inflight_q, inflight_last_q;
    logic                  done_q, done_d;

    logic                  issue;
    logic                  issue_last;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  pop;
    logic [OCC_W-1:0]      occupancy;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [DATA_WIDTH:0]   fifo_head;

    assign pop = out_valid && out_ready;
    // Slots that will be claimed once everything already requested has landed.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        issue_last  = 1'b0;
        issue_addr  = next_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        issue       = 1'b1;
                        issue_addr  = base_addr;
                        issue_last  = (length == LEN_W'(1));
                        remaining_d = length - LEN_W'(1);
                        state_d     = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (remaining_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (occupancy < OCC_W'(FIFO_DEPTH)) begin
                    issue       = 1'b1;
                    issue_last  = (remaining_q == LEN_W'(1));
                    remaining_d = remaining_q - LEN_W'(1);
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && out_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue) begin
            next_addr_d = issue_addr + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            next_addr_q     <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= ram_addr;
            next_addr_q     <= next_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            done_q          <= done_d;
        end
    end

    stream_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight_q),
        .push_data ({inflight_last_q, ram_dout}),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign ram_port_en = 1'b0;
    assign ram_addr    = issue ? issue_addr : addr_q;
    assign out_valid   = (fifo_count != '0);
    assign out_data    = fifo_head[DATA_WIDTH-1:0];
    assign out_last    = out_valid && fifo_head[DATA_WIDTH];
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_stream_reader
// Brief    : Directed self-checking bench for ram_stream_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_stream_reader;

    localparam int AW = 12;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          ram_port_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    int            got_cyc  [$];
    int            done_cyc;
    int            done_cnt;
    int            busy_cnt;
    int            stall_err;
    logic          done_at_start;
    logic [15:0]   rdy_pat = 16'b1001_1100_1011_0010;

    ram_stream_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .ram_port_en (ram_port_en),
        .ram_addr    (ram_addr),
        .ram_dout    (ram_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= mem[ram_addr];

    // Cycle k=0 is the start cycle; inputs driven and outputs sampled at negedge.
    task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] len,
                             input bit stall, input int ncyc, input int restart_k);
        logic [DW-1:0] held_data;
        logic          held_last;
        bit            holding;
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; stall_err = 0;
        holding = 1'b0; done_at_start = 1'b0;
        held_data = '0; held_last = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b1; base_addr = base; length = len; done_at_start = done;
            end else if (k == restart_k) begin
                start = 1'b1; base_addr = 12'h300; length = 13'd2;
            end else begin
                start = 1'b0;
            end
            out_ready = stall ? rdy_pat[k % 16] : 1'b1;
            if (k > 0 && done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (k > 0 && busy) busy_cnt++;
            if (holding && (!out_valid || out_data !== held_data || out_last !== held_last))
                stall_err++;
            holding   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_cyc.push_back(k);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", out_last); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", out_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (ram_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", ram_addr); end
        checks++; if (ram_port_en !== 1'b0) begin failures++; $display("FAIL reset_port_en got=%b exp=0", ram_port_en); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_burst(12'h010, 13'd4, 1'b0, 10, -1);
        checks++; if (got_data.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== 64'(32'h10 + i)) begin failures++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, got_data[i], 32'h10 + i); end
            checks++; if (got_last[i] !== (i == 3)) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, got_last[i], i == 3); end
            checks++; if (got_cyc[i] != 2 + i) begin failures++; $display("FAIL basic_cycle[%0d] got=%0d exp=%0d", i, got_cyc[i], 2 + i); end
        end
        checks++; if (done_cyc != 6) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=6", done_cyc); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
        checks++; if (busy_cnt != 5) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=5", busy_cnt); end
        checks++; if (ram_port_en !== 1'b0) begin failures++; $display("FAIL basic_port_en got=%b exp=0", ram_port_en); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp_w [4];
        exp_w[0] = 64'hFFE; exp_w[1] = 64'hFFF; exp_w[2] = 64'h000; exp_w[3] = 64'h001;
        run_burst(12'hFFE, 13'd4, 1'b0, 10, -1);
        checks++; if (got_data.size() != 4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_w[i]) begin failures++; $display("FAIL wrap_data[%0d] got=%0h exp=%0h", i, got_data[i], exp_w[i]); end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL wrap_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_stall();
        run_burst(12'h040, 13'd8, 1'b1, 60, -1);
        checks++; if (got_data.size() != 8) begin failures++; $display("FAIL stall_count got=%0d exp=8", got_data.size()); end
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== 64'(32'h40 + i)) begin failures++; $display("FAIL stall_data[%0d] got=%0h exp=%0h", i, got_data[i], 32'h40 + i); end
            checks++; if (got_last[i] !== (i == 7)) begin failures++; $display("FAIL stall_last[%0d] got=%b exp=%b", i, got_last[i], i == 7); end
        end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL stall_stability got=%0d exp=0", stall_err); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL stall_done_count got=%0d exp=1", done_cnt); end
        if (got_cyc.size() == 8) begin
            checks++; if (done_cyc != got_cyc[7] + 1) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=%0d", done_cyc, got_cyc[7] + 1); end
        end
    endtask

    task automatic test_zero_len();
        run_burst(12'h055, 13'd0, 1'b0, 6, -1);
        checks++; if (got_data.size() != 0) begin failures++; $display("FAIL zero_words got=%0d exp=0", got_data.size()); end
        checks++; if (done_cyc != 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cyc); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
        checks++; if (busy_cnt != 0) begin failures++; $display("FAIL zero_busy got=%0d exp=0", busy_cnt); end
    endtask

    task automatic test_start_while_busy();
        run_burst(12'h200, 13'd4, 1'b0, 14, 2);
        checks++; if (got_data.size() != 4) begin failures++; $display("FAIL busy_start_count got=%0d exp=4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== 64'(32'h200 + i)) begin failures++; $display("FAIL busy_start_data[%0d] got=%0h exp=%0h", i, got_data[i], 32'h200 + i); end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_cyc != 6) begin failures++; $display("FAIL busy_start_done_cycle got=%0d exp=6", done_cyc); end
    endtask

    task automatic test_reset_mid();
        int late_valid;
        int late_done;
        int late_busy;
        run_burst(12'h100, 13'd8, 1'b0, 5, -1);
        checks++; if (got_data.size() != 3) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=3", got_data.size()); end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL midrst_last got=%b exp=0", out_last); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL midrst_data got=%0h exp=0", out_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (ram_addr !== '0) begin failures++; $display("FAIL midrst_addr got=%0h exp=0", ram_addr); end
        @(negedge clk);
        rstn = 1'b1;
        late_valid = 0; late_done = 0; late_busy = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) late_valid++;
            if (done) late_done++;
            if (busy) late_busy++;
        end
        checks++; if (late_valid != 0) begin failures++; $display("FAIL midrst_late_words got=%0d exp=0", late_valid); end
        checks++; if (late_done != 0) begin failures++; $display("FAIL midrst_late_done got=%0d exp=0", late_done); end
        checks++; if (late_busy != 0) begin failures++; $display("FAIL midrst_late_busy got=%0d exp=0", late_busy); end
    endtask

    task automatic test_back_to_back();
        run_burst(12'h020, 13'd3, 1'b0, 5, -1);
        checks++; if (got_data.size() != 3) begin failures++; $display("FAIL b2b_first_count got=%0d exp=3", got_data.size()); end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== 64'(32'h20 + i)) begin failures++; $display("FAIL b2b_first_data[%0d] got=%0h exp=%0h", i, got_data[i], 32'h20 + i); end
        end
        run_burst(12'h030, 13'd4, 1'b0, 10, -1);
        checks++; if (done_at_start !== 1'b1) begin failures++; $display("FAIL b2b_start_in_done got=%b exp=1", done_at_start); end
        checks++; if (got_data.size() != 4) begin failures++; $display("FAIL b2b_second_count got=%0d exp=4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== 64'(32'h30 + i)) begin failures++; $display("FAIL b2b_second_data[%0d] got=%0h exp=%0h", i, got_data[i], 32'h30 + i); end
            checks++; if (got_cyc[i] != 2 + i) begin failures++; $display("FAIL b2b_second_cycle[%0d] got=%0d exp=%0d", i, got_cyc[i], 2 + i); end
        end
        checks++; if (done_cyc != 6) begin failures++; $display("FAIL b2b_second_done_cycle got=%0d exp=6", done_cyc); end
    endtask

    initial begin
        for (int k = 0; k < (1 << AW); k++) mem[k] = 64'(k);
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_len();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
